dcache_arbiter: RTL and testbench

- Shares the single data-cache port between two requesters: master 0 is the CPU memory interface and master 1 is a secondary engine (DMA/blitter).
- Grants one request per cycle using round-robin priority and forwards it to the dcache.
- Records the owner of every outstanding read in an in-order tag FIFO, so each returned read is routed back to the master that issued it.
- Supports the one-cycle-late abort from master 0.

---
 rtl/dcache_arbiter_pkg.sv | 17 +
 rtl/dcache_arbiter_tag_fifo.sv | 55 +++++
 rtl/dcache_arbiter.sv | 121 ++++++++++++
 tb/tb_dcache_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arbiter_pkg.sv
// Shared types for the data-cache arbiter: master ids and the request payload.
package dcache_arbiter_pkg;

  // One bit is enough to name the owner of a request.
  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_AUX = 1'b1;

  // Request payload that does not depend on the address width.
  typedef struct packed {
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_payload_t;

endpackage

// File: rtl/dcache_arbiter_tag_fifo.sv
// In-order owner FIFO for outstanding reads. drop_tail removes the youngest
// entry (an aborted read); it can coincide with a pop and/or a push.
module tag_fifo
  import dcache_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  master_id_t push_id,
  input  logic       pop,
  input  logic       drop_tail,
  output master_id_t head,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  master_id_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_slot;
  logic          do_pop, do_drop;

  // Ignore pops of an empty FIFO; a drop must leave the popped head alone.
  assign do_pop  = pop && !empty;
  assign do_drop = drop_tail && (count > (AW+1)'(do_pop));
  // A drop rewinds the tail, so a same-cycle push reuses the dropped slot.
  assign wr_slot = do_drop ? wr_ptr - 1'b1 : wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= push ? wr_slot + 1'b1 : wr_slot;
      count  <= count + (AW+1)'(push) - (AW+1)'(do_pop) - (AW+1)'(do_drop);
    end
  end

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clock) begin
    if (push) mem[wr_slot] <= push_id;
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter sharing the dcache port between the CPU (master 0)
// and an auxiliary engine (master 1), with read-return routing and the
// master 0 late abort.
module dcache_arbiter
  import dcache_arbiter_pkg::*;
#(
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_request,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m0_abort,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_request,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              dc_request,
  output logic              dc_write,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_wdata,
  output logic [3:0]        dc_wstrb,
  output logic              dc_abort,
  input  logic              dc_ready,
  input  logic              dc_rvalid,
  input  logic [31:0]       dc_rdata,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  master_id_t   last_grant, winner, fifo_head;
  logic         prev_acc_m0, prev_acc_m0_read;
  logic         fifo_full, fifo_empty, room, drop, pop, accept;
  logic         cand0, cand1;
  logic [AW:0]  fifo_count;
  req_payload_t pay0, pay1, pay_win;

  assign pay0 = '{write: m0_write, wdata: m0_wdata, wstrb: m0_wstrb};
  assign pay1 = '{write: m1_write, wdata: m1_wdata, wstrb: m1_wstrb};

  // A late abort names the read accepted last cycle.
  assign dc_abort = !reset && m0_abort && prev_acc_m0;
  assign drop     = dc_abort && prev_acc_m0_read;
  assign pop      = !reset && dc_rvalid && !fifo_empty;

  // A returning or aborted read frees its slot in the same cycle.
  assign room  = !fifo_full || pop || drop;
  assign cand0 = m0_request && (m0_write || room);
  assign cand1 = m1_request && (m1_write || room);

  // On contention the master that did not win last time goes first.
  assign winner = (cand0 && cand1) ? ~last_grant : cand1;

  assign dc_request = !reset && (cand0 || cand1);
  assign pay_win    = (winner == MASTER_AUX) ? pay1 : pay0;
  assign dc_addr    = (winner == MASTER_AUX) ? m1_addr : m0_addr;
  assign dc_write   = pay_win.write;
  assign dc_wdata   = pay_win.wdata;
  assign dc_wstrb   = pay_win.wstrb;

  assign accept   = dc_request && dc_ready;
  assign m0_ready = accept && (winner == MASTER_CPU);
  assign m1_ready = accept && (winner == MASTER_AUX);

  // Read data fans out to both masters; only the owner sees rvalid.
  assign m0_rvalid = pop && (fifo_head == MASTER_CPU);
  assign m1_rvalid = pop && (fifo_head == MASTER_AUX);
  assign m0_rdata  = dc_rdata;
  assign m1_rdata  = dc_rdata;

  assign busy = (fifo_count != '0) || m0_request || m1_request;

  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept && !dc_write),
    .push_id   (winner),
    .pop       (pop),
    .drop_tail (drop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Round-robin pointer and the one-cycle abort window.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant       <= MASTER_AUX;
      prev_acc_m0      <= 1'b0;
      prev_acc_m0_read <= 1'b0;
    end else begin
      if (accept) last_grant <= winner;
      prev_acc_m0      <= accept && (winner == MASTER_CPU);
      prev_acc_m0_read <= accept && (winner == MASTER_CPU) && !dc_write;
    end
  end

`ifndef SYNTHESIS
  // Protocol diagnostics for simulation.
  always_ff @(posedge clock) begin
    if (!reset && dc_rvalid && fifo_empty)
      $display("dcache_arbiter: protocol error, rvalid with no outstanding read (data %h dropped)", dc_rdata);
    if (!reset && m0_abort && !prev_acc_m0)
      $display("dcache_arbiter: protocol error, m0_abort with no accepted m0 request");
  end
`endif

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: a queue-based owner model checked every
// cycle, plus literal expectations along the scripted scenarios.
module tb_dcache_arbiter;
  localparam int ADDR_W = 26;
  localparam int DEPTH  = 4;

  logic clock = 0, reset = 1;
  logic m0_request = 0, m0_write = 0, m0_abort = 0;
  logic [ADDR_W-1:0] m0_addr = 26'h100;
  logic [31:0] m0_wdata = 0;
  logic [3:0]  m0_wstrb = 0;
  logic m1_request = 0, m1_write = 0;
  logic [ADDR_W-1:0] m1_addr = 26'h300;
  logic [31:0] m1_wdata = 32'h5555_AAAA;
  logic [3:0]  m1_wstrb = 4'h3;
  logic dc_ready = 1, dc_rvalid = 0;
  logic [31:0] dc_rdata = 0;
  logic m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, dc_wdata;
  logic dc_request, dc_write, dc_abort, busy;
  logic [ADDR_W-1:0] dc_addr;
  logic [3:0] dc_wstrb;

  int vectors = 0, miscompares = 0;

  dcache_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .m0_request(m0_request), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_abort(m0_abort),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_request(m1_request), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dc_request(dc_request), .dc_write(dc_write), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_abort(dc_abort),
    .dc_ready(dc_ready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: owners of outstanding reads, oldest first.
  int q[$];
  int lg = 1;
  bit pm0 = 0, pm0r = 0;

  typedef struct {
    bit req, win, r0, r1, v0, v1, abort, busy, pop, drop;
  } exp_t;

  function automatic exp_t model();
    exp_t e;
    int n, free;
    bit c0, c1;
    e = '{default: 0};
    n = q.size();
    e.busy = (n > 0) || m0_request || m1_request;
    if (reset) return e;
    e.pop   = dc_rvalid && n > 0;
    e.abort = m0_abort && pm0;
    e.drop  = e.abort && pm0r;
    free = DEPTH - n + int'(e.pop) + int'(e.drop);
    c0 = m0_request && (m0_write || free > 0);
    c1 = m1_request && (m1_write || free > 0);
    if (c0 && c1) e.win = (lg == 0);
    else          e.win = c1;
    e.req = c0 || c1;
    e.r0  = e.req && !e.win && dc_ready;
    e.r1  = e.req &&  e.win && dc_ready;
    e.v0  = e.pop && q[0] == 0;
    e.v1  = e.pop && q[0] == 1;
    return e;
  endfunction

  // Advance the model on each clock edge from the inputs held across it.
  always @(posedge clock) begin
    exp_t e;
    bit acc, wr;
    e = model();
    if (reset) begin
      q.delete(); lg = 1; pm0 = 0; pm0r = 0;
    end else begin
      if (e.pop) void'(q.pop_front());
      if (e.drop && q.size() > 0) void'(q.pop_back());
      acc = e.req && dc_ready;
      wr  = e.win ? m1_write : m0_write;
      if (acc && !wr) q.push_back(int'(e.win));
      if (acc) lg = int'(e.win);
      pm0  = acc && !e.win;
      pm0r = pm0 && !wr;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    e = model();
    check("dc_request", dc_request, e.req);
    check("m0_ready", m0_ready, e.r0);
    check("m1_ready", m1_ready, e.r1);
    check("m0_rvalid", m0_rvalid, e.v0);
    check("m1_rvalid", m1_rvalid, e.v1);
    check("dc_abort", dc_abort, e.abort);
    check("busy", busy, e.busy);
    if (e.req) begin
      check("dc_addr", dc_addr, e.win ? m1_addr : m0_addr);
      check("dc_write", dc_write, e.win ? m1_write : m0_write);
      check("dc_wdata", dc_wdata, e.win ? m1_wdata : m0_wdata);
      check("dc_wstrb", dc_wstrb, e.win ? m1_wstrb : m0_wstrb);
    end
    if (e.v0) check("m0_rdata", m0_rdata, dc_rdata);
    if (e.v1) check("m1_rdata", m1_rdata, dc_rdata);
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    m0_request = 0; m1_request = 0; m0_write = 0; m1_write = 0;
    m0_abort = 0; dc_rvalid = 0; dc_ready = 1;
  endtask

  task automatic ret(input logic [31:0] d);
    dc_rvalid = 1; dc_rdata = d;
  endtask

  initial begin
    logic [31:0] sv_addr;
    // Reset state
    tick(); tick();
    m0_request = 1; #1;
    check("reset m0_ready", m0_ready, 0);
    check("reset dc_request", dc_request, 0);
    tick(); reset = 0; m0_request = 0; #1;
    check("post-reset busy", busy, 0);

    // Single master read, data two cycles later
    m0_request = 1; m0_addr = 26'h100; #1;
    check("t1 m0_ready", m0_ready, 1);
    check("t1 dc_addr", dc_addr, 26'h100);
    tick(); idle();
    tick(); ret(32'hDEADBEEF); #1;
    check("t1 m0_rvalid", m0_rvalid, 1);
    check("t1 m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1 m1_rvalid", m1_rvalid, 0);
    tick(); idle();

    // Contention: last winner was m0, so grants go m1,m0,m1,m0
    for (int i = 0; i < 4; i++) begin
      m0_request = 1; m1_request = 1; #1;
      check("t2 m1_ready", m1_ready, (i % 2 == 0));
      check("t2 m0_ready", m0_ready, (i % 2 == 1));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      ret(32'h11 * (i + 1)); #1;
      check("t2 m1_rvalid", m1_rvalid, (i % 2 == 0));
      check("t2 m0_rvalid", m0_rvalid, (i % 2 == 1));
      tick();
    end
    idle();

    // FIFO full with four m1 reads
    m1_request = 1;
    for (int i = 0; i < 4; i++) tick();
    idle(); m0_request = 1; #1;
    check("t3 full m0_ready", m0_ready, 0);
    check("t3 full dc_request", dc_request, 0);
    tick(); m0_write = 1; m0_addr = 26'h200; m0_wdata = 32'hCAFE_F00D; m0_wstrb = 4'hF; #1;
    check("t3 write m0_ready", m0_ready, 1);
    check("t3 write dc_wstrb", dc_wstrb, 4'hF);
    tick(); m0_write = 0; m0_addr = 26'h104; ret(32'hA1); #1;
    check("t3 free+grant m0_ready", m0_ready, 1);
    check("t3 free m1_rvalid", m1_rvalid, 1);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin ret(32'hB0 + i); tick(); end
    ret(32'hC0); #1;
    check("t3 last m0_rvalid", m0_rvalid, 1);
    tick(); idle();

    // Abort of a lone m0 read
    m0_request = 1; tick(); idle();
    m0_abort = 1; #1;
    check("t4 dc_abort", dc_abort, 1);
    tick(); idle(); #1;
    check("t4 busy after abort", busy, 0);
    m1_request = 1; tick(); idle();
    ret(32'h1234); #1;
    check("t4 m1_rvalid", m1_rvalid, 1);
    check("t4 m0_rvalid", m0_rvalid, 0);
    tick(); idle();

    // Abort coincides with the pop of the head
    m1_request = 1; tick(); idle();
    m0_request = 1; tick(); idle();
    m0_abort = 1; ret(32'h5678); #1;
    check("t4b m1_rvalid", m1_rvalid, 1);
    check("t4b dc_abort", dc_abort, 1);
    tick(); idle(); #1;
    check("t4b busy", busy, 0);

    // Stalled dcache: last winner m0, so m1 is presented and held
    m0_request = 1; m1_request = 1; dc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5 stall m0_ready", m0_ready, 0);
      check("t5 stall m1_ready", m1_ready, 0);
      check("t5 stall dc_addr", dc_addr, 26'h300);
      tick();
    end
    dc_ready = 1; #1;
    check("t5 release m1_ready", m1_ready, 1);
    tick(); idle();
    ret(32'h9); tick(); idle();

    // Reset with three reads outstanding
    m0_request = 1;
    for (int i = 0; i < 3; i++) tick();
    idle(); reset = 1; tick(); reset = 0; #1;
    check("t6 busy after reset", busy, 0);
    m0_request = 1; m1_request = 1; #1;
    check("t6 m0 wins first", m0_ready, 1);
    tick(); #1;
    check("t6 m1 wins next", m1_ready, 1);
    sv_addr = 32'(dc_addr);
    check("t6 dc_addr", sv_addr, 32'h300);
    tick(); idle();
    ret(32'hE0); #1;
    check("t6 first return m0", m0_rvalid, 1);
    tick(); ret(32'hE1); #1;
    check("t6 second return m1", m1_rvalid, 1);
    tick(); idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
